// File: rtl/sm83_int_ctrl.sv
// SM83 interrupt controller: IF/IE registers on the CPU bus, request edge capture,
// lowest-bit-first priority and RST vector return on the core's dispatch acknowledge.
module sm83_int_ctrl #(
   parameter logic [15:0] IF_ADDR    = 16'hFF0F,
   parameter logic [15:0] IE_ADDR    = 16'hFFFF,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter int unsigned VEC_STRIDE = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  irq_src_i,
   input  logic [15:0] bus_addr_i,
   input  logic [7:0]  bus_wdata_i,
   input  logic        bus_wr_i,
   input  logic        bus_rd_i,
   output logic [7:0]  bus_rdata_o,
   output logic        bus_hit_o,
   output logic        int_pending_o,
   input  logic        int_ack_i,
   output logic        ack_done_o,
   output logic [15:0] ack_vec_o
);

   logic [4:0]  if_q, if_d;
   logic [7:0]  ie_q, ie_d;
   logic [4:0]  prev_src_q;
   logic [7:0]  rdata_q, rdata_d;
   logic        ack_done_q;
   logic [15:0] ack_vec_q, ack_vec_d;

   logic        hit_if, hit_ie;
   logic        wr_if, wr_ie;
   logic [4:0]  masked;
   logic [4:0]  set_vec, clr_vec;
   logic [2:0]  sel_idx;
   logic        sel_valid;

   assign hit_if    = (bus_addr_i == IF_ADDR);
   assign hit_ie    = (bus_addr_i == IE_ADDR);
   assign bus_hit_o = hit_if | hit_ie;
   assign wr_if     = bus_wr_i & hit_if;
   assign wr_ie     = bus_wr_i & hit_ie;

   assign masked        = ie_q[4:0] & if_q;
   assign int_pending_o = |masked;
   assign set_vec       = irq_src_i & ~prev_src_q;

   // Descending scan so the lowest set bit is the one left in sel_idx.
   always_comb begin
      sel_idx   = 3'd0;
      sel_valid = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         if (masked[i]) begin
            sel_idx   = 3'(i);
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      clr_vec = 5'h00;
      if (int_ack_i && sel_valid) clr_vec = 5'(5'b00001 << sel_idx);
   end

   // Software write first, then ack clear, then peripheral edges override both.
   assign if_d = ((wr_if ? bus_wdata_i[4:0] : if_q) & ~clr_vec) | set_vec;
   assign ie_d = wr_ie ? bus_wdata_i : ie_q;

   always_comb begin
      rdata_d = rdata_q;
      if (bus_rd_i && hit_if)      rdata_d = {3'b111, if_q};
      else if (bus_rd_i && hit_ie) rdata_d = ie_q;
   end

   // A cancelled dispatch (nothing selected at ack time) returns vector 0x0000.
   always_comb begin
      ack_vec_d = ack_vec_q;
      if (int_ack_i) begin
         ack_vec_d = sel_valid ? (VEC_BASE + 16'(VEC_STRIDE) * 16'(sel_idx)) : 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_q       <= 5'h00;
         ie_q       <= 8'h00;
         prev_src_q <= 5'h00;
         rdata_q    <= 8'h00;
         ack_done_q <= 1'b0;
         ack_vec_q  <= 16'h0000;
      end else begin
         if_q       <= if_d;
         ie_q       <= ie_d;
         prev_src_q <= irq_src_i;
         rdata_q    <= rdata_d;
         ack_done_q <= int_ack_i;
         ack_vec_q  <= ack_vec_d;
      end
   end

   assign bus_rdata_o = rdata_q;
   // A reset landing in the delivery cycle suppresses the pulse.
   assign ack_done_o  = ack_done_q & ~rst;
   assign ack_vec_o   = ack_vec_q;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Directed bench for sm83_int_ctrl: linear steps, immediate-assertion checks,
// hand-computed expected values.
module tb_sm83_int_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  irq_src_i = 5'h00;
   logic [15:0] bus_addr_i = 16'h0000;
   logic [7:0]  bus_wdata_i = 8'h00;
   logic        bus_wr_i = 1'b0;
   logic        bus_rd_i = 1'b0;
   logic [7:0]  bus_rdata_o;
   logic        bus_hit_o;
   logic        int_pending_o;
   logic        int_ack_i = 1'b0;
   logic        ack_done_o;
   logic [15:0] ack_vec_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   sm83_int_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src_i     (irq_src_i),
      .bus_addr_i    (bus_addr_i),
      .bus_wdata_i   (bus_wdata_i),
      .bus_wr_i      (bus_wr_i),
      .bus_rd_i      (bus_rd_i),
      .bus_rdata_o   (bus_rdata_o),
      .bus_hit_o     (bus_hit_o),
      .int_pending_o (int_pending_o),
      .int_ack_i     (int_ack_i),
      .ack_done_o    (ack_done_o),
      .ack_vec_o     (ack_vec_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      bus_addr_i  = addr;
      bus_wdata_i = data;
      bus_wr_i    = 1'b1;
      tick();
      bus_wr_i    = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
      bus_addr_i = addr;
      bus_rd_i   = 1'b1;
      tick();
      bus_rd_i   = 1'b0;
      data       = bus_rdata_o;
   endtask

   task automatic ack_pulse();
      int_ack_i = 1'b1;
      tick();
      int_ack_i = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;

      // Reset
      tick();
      tick();
      chk("rst_ack_done", 16'(ack_done_o), 16'h0000);
      chk("rst_ack_vec", ack_vec_o, 16'h0000);
      chk("rst_rdata", 16'(bus_rdata_o), 16'h0000);
      chk("rst_pending", 16'(int_pending_o), 16'h0000);
      rst = 1'b0;
      tick();

      // 1: held Timer level, IE = 04
      bus_write(16'hFFFF, 8'h04);
      irq_src_i = 5'b00100;
      #1;
      chk("t1_pending_same_cycle", 16'(int_pending_o), 16'h0000);
      tick();
      chk("t1_pending_next", 16'(int_pending_o), 16'h0001);
      tick();
      bus_read(16'hFF0F, rd);
      chk("t1_read_if", 16'(rd), 16'h00E4);
      ack_pulse();
      chk("t1_ack_done", 16'(ack_done_o), 16'h0001);
      chk("t1_ack_vec", ack_vec_o, 16'h0050);
      tick();
      chk("t1_ack_done_drop", 16'(ack_done_o), 16'h0000);
      tick();
      chk("t1_no_reset_held", 16'(int_pending_o), 16'h0000);
      bus_read(16'hFF0F, rd);
      chk("t1_read_if_cleared", 16'(rd), 16'h00E0);
      tick();
      irq_src_i = 5'h00;
      tick();

      // 2: STAT and Serial together, two acks
      bus_write(16'hFFFF, 8'h1F);
      irq_src_i = 5'b01010;
      tick();
      irq_src_i = 5'h00;
      ack_pulse();
      chk("t2_ack1_done", 16'(ack_done_o), 16'h0001);
      chk("t2_ack1_vec", ack_vec_o, 16'h0048);
      bus_read(16'hFF0F, rd);
      chk("t2_if_after_ack1", 16'(rd), 16'h00E8);
      ack_pulse();
      chk("t2_ack2_vec", ack_vec_o, 16'h0058);
      bus_read(16'hFF0F, rd);
      chk("t2_if_after_ack2", 16'(rd), 16'h00E0);
      chk("t2_vec_held", ack_vec_o, 16'h0058);

      // 3: cancelled dispatch
      bus_write(16'hFF0F, 8'h01);
      bus_write(16'hFFFF, 8'h01);
      chk("t3_pending", 16'(int_pending_o), 16'h0001);
      bus_write(16'hFFFF, 8'h00);
      ack_pulse();
      chk("t3_ack_done", 16'(ack_done_o), 16'h0001);
      chk("t3_ack_vec", ack_vec_o, 16'h0000);
      bus_read(16'hFF0F, rd);
      chk("t3_if_kept", 16'(rd), 16'h00E1);

      // 4: write IF=0, ack Timer and Joypad edge, all in one cycle
      bus_write(16'hFF0F, 8'h04);
      bus_write(16'hFFFF, 8'h04);
      bus_addr_i  = 16'hFF0F;
      bus_wdata_i = 8'h00;
      bus_wr_i    = 1'b1;
      int_ack_i   = 1'b1;
      irq_src_i   = 5'b10000;
      tick();
      bus_wr_i  = 1'b0;
      int_ack_i = 1'b0;
      irq_src_i = 5'h00;
      chk("t4_ack_vec", ack_vec_o, 16'h0050);
      bus_read(16'hFF0F, rd);
      chk("t4_if", 16'(rd), 16'h00F0);

      // 5: bus register checks
      bus_write(16'hFFFF, 8'hE5);
      bus_read(16'hFFFF, rd);
      chk("t5_ie_read", 16'(rd), 16'h00E5);
      bus_write(16'hFF0F, 8'hFF);
      bus_read(16'hFF0F, rd);
      chk("t5_if_read", 16'(rd), 16'h00FF);
      bus_addr_i = 16'hFF10;
      #1;
      chk("t5_hit_miss", 16'(bus_hit_o), 16'h0000);
      bus_addr_i = 16'hFF0F;
      #1;
      chk("t5_hit_if", 16'(bus_hit_o), 16'h0001);
      bus_write(16'hFF10, 8'h00);
      bus_read(16'hFF10, rd);
      chk("t5_miss_read_keeps", 16'(rd), 16'h00FF);
      bus_read(16'hFFFF, rd);
      chk("t5_ie_unchanged", 16'(rd), 16'h00E5);
      bus_read(16'hFF0F, rd);
      chk("t5_if_unchanged", 16'(rd), 16'h00FF);

      // 6: reset in the delivery cycle, VBlank held through reset
      ack_pulse();
      rst       = 1'b1;
      irq_src_i = 5'b00001;
      #1;
      chk("t6_ack_done_suppressed", 16'(ack_done_o), 16'h0000);
      tick();
      chk("t6_rdata_reset", 16'(bus_rdata_o), 16'h0000);
      chk("t6_vec_reset", ack_vec_o, 16'h0000);
      chk("t6_pending_reset", 16'(int_pending_o), 16'h0000);
      tick();
      rst = 1'b0;
      tick();
      bus_read(16'hFF0F, rd);
      chk("t6_if_after_rst", 16'(rd), 16'h00E1);
      bus_read(16'hFFFF, rd);
      chk("t6_ie_after_rst", 16'(rd), 16'h0000);
      irq_src_i = 5'h00;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
